// File: rtl/fp_dot_lanes_module.sv
// fp_dot_lanes_module
// Multi-lane FP32 dot-product accumulator. Each accepted beat multiplies LANES
// operand pairs, reduces them through a registered adder tree and adds (or
// subtracts) the beat sum into a running accumulator. A vector closes on
// in_last or on the LEN_MAX-th beat. An optional bias is then added, and the
// result is held on a ready/valid output until taken.
//
// All arithmetic is FP32 round-toward-zero, with denormals flushed to +0.
// An exact-zero sum gives +0, and exponent overflow gives signed infinity.
//
// Ports
//   aclk, areset        clock, async active-high reset
//   in_A, in_B          lane i operands at [32i+31:32i]
//   in_lane_mask        per-lane enable (0 forces the lane product to +0)
//   in_acc_sign         1 = add beat sum, 0 = subtract it
//   in_valid/in_ready   beat handshake
//   in_last             closes the vector (honoured whenever in_ready=1)
//   custom_last         FP32 bias, taken on the close cycle when en_custom_last=1
//   en_custom_last      bias enable
//   result_all          accumulated FP32 result
//   sendable            result valid
//   result_ready        downstream accepts the result
//   beat_count          beats accepted in the current vector (saturating)
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | empty vector, waiting for the first beat or in_last
// ACC   | accumulating beats
// DRAIN | vector closed, in-flight beats still in the pipeline
// BIAS  | single cycle: acc <= acc + bias
// DONE  | result presented, waiting for result_ready

module fp_dot_lanes_module #(
   parameter int LANES   = 4,
   parameter int LEN_MAX = 8
) (
   input  logic                  aclk,
   input  logic                  areset,
   input  logic [32*LANES-1:0]   in_A,
   input  logic [32*LANES-1:0]   in_B,
   input  logic [LANES-1:0]      in_lane_mask,
   input  logic                  in_acc_sign,
   input  logic                  in_valid,
   input  logic                  in_last,
   output logic                  in_ready,
   input  logic [31:0]           custom_last,
   input  logic                  en_custom_last,
   output logic [31:0]           result_all,
   output logic                  sendable,
   input  logic                  result_ready,
   output logic [7:0]            beat_count
);

   localparam int         LOG2      = $clog2(LANES);
   localparam logic [7:0] LEN_LAST  = 8'(LEN_MAX - 1);
   localparam logic [7:0] LEN_SAT   = 8'(LEN_MAX);
   // DRAIN lasts LOG2+2 cycles: operand reg, product reg, LOG2 tree levels
   // and the accumulator add must all have seen the last beat.
   localparam logic [3:0] DRAIN_CYC = 4'(LOG2 + 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ACC   = 3'd1,
      DRAIN = 3'd2,
      BIAS  = 3'd3,
      DONE  = 3'd4
   } state_t;

   state_t state, state_nxt;

   // ------------------------------------------------------------------
   // FP32 helpers (round toward zero, flush-to-zero)
   // ------------------------------------------------------------------
   function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
      logic               s;
      logic signed [10:0] e;
      logic [47:0]        p;
      logic [22:0]        m;
      s = a[31] ^ b[31];
      if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return 32'h0;
      p = {1'b1, a[22:0]} * {1'b1, b[22:0]};
      e = $signed({3'b000, a[30:23]}) + $signed({3'b000, b[30:23]}) - 11'sd127;
      if (p[47]) begin
         m = p[46:24];
         e = e + 11'sd1;
      end else begin
         m = p[45:23];
      end
      if (e <= 11'sd0)   return 32'h0;
      if (e >= 11'sd255) return {s, 8'hFF, 23'h0};
      return {s, e[7:0], m};
   endfunction

   function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
      logic [31:0]        x, y;
      logic [7:0]         d;
      logic [26:0]        mx, my, mys, s27;
      logic [27:0]        sum28;
      logic signed [10:0] e;
      logic [4:0]         lz;
      logic               found;
      logic               lost;
      if (a[30:23] == 8'd0 && b[30:23] == 8'd0) return 32'h0;
      if (a[30:23] == 8'd0) return b;
      if (b[30:23] == 8'd0) return a;
      // x always carries the larger magnitude so the difference is non-negative
      if (b[30:0] > a[30:0]) begin
         x = b;
         y = a;
      end else begin
         x = a;
         y = b;
      end
      d  = x[30:23] - y[30:23];
      mx = {1'b1, x[22:0], 3'b000};
      my = {1'b1, y[22:0], 3'b000};
      // guard/round/sticky bits keep the truncated result exact for RTZ
      if (d >= 8'd27) begin
         mys = 27'd1;
      end else begin
         mys    = my >> d;
         lost   = |(my & ((27'd1 << d) - 27'd1));
         mys[0] = mys[0] | lost;
      end
      e = $signed({3'b000, x[30:23]});
      if (x[31] == y[31]) begin
         sum28 = {1'b0, mx} + {1'b0, mys};
         if (sum28[27]) begin
            s27 = sum28[27:1];
            e   = e + 11'sd1;
         end else begin
            s27 = sum28[26:0];
         end
      end else begin
         s27 = mx - mys;
         if (s27 == 27'd0) return 32'h0;
         lz    = 5'd0;
         found = 1'b0;
         for (int i = 26; i >= 0; i--) begin
            if (!found) begin
               if (s27[i]) found = 1'b1;
               else        lz    = lz + 5'd1;
            end
         end
         s27 = s27 << lz;
         e   = e - $signed({6'b000000, lz});
      end
      if (e <= 11'sd0)   return 32'h0;
      if (e >= 11'sd255) return {x[31], 8'hFF, 23'h0};
      return {x[31], e[7:0], s27[25:3]};
   endfunction

   // ------------------------------------------------------------------
   // Handshake / control
   // ------------------------------------------------------------------
   logic        rdy_en;
   logic        beat_acc;
   logic        close;
   logic        take;
   logic [3:0]  drain_cnt;
   logic [31:0] bias_q;
   logic [31:0] acc;

   assign in_ready   = rdy_en && (state == IDLE || state == ACC);
   assign beat_acc   = in_valid && in_ready;
   assign close      = in_ready && (in_last || (in_valid && beat_count == LEN_LAST));
   assign sendable   = (state == DONE);
   assign take       = sendable && result_ready;
   assign result_all = acc;

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (close) state_nxt = DRAIN;
                  else if (beat_acc) state_nxt = ACC;
         ACC:     if (close) state_nxt = DRAIN;
         DRAIN:   if (drain_cnt == 4'd0) state_nxt = BIAS;
         BIAS:    state_nxt = DONE;
         DONE:    if (result_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // in_ready stays low while in reset and comes up on the first edge after
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) rdy_en <= 1'b0;
      else        rdy_en <= 1'b1;
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         beat_count <= 8'd0;
         drain_cnt  <= 4'd0;
         bias_q     <= 32'h0;
      end else begin
         if (take)
            beat_count <= 8'd0;
         else if (beat_acc && beat_count != LEN_SAT)
            beat_count <= beat_count + 8'd1;

         if (close)
            drain_cnt <= DRAIN_CYC;
         else if (state == DRAIN && drain_cnt != 4'd0)
            drain_cnt <= drain_cnt - 4'd1;

         if (close)
            bias_q <= en_custom_last ? custom_last : 32'h0;
      end
   end

   // ------------------------------------------------------------------
   // Datapath: operand reg -> product reg -> LOG2 tree levels -> acc
   // ------------------------------------------------------------------
   logic [32*LANES-1:0] a_masked;
   logic [32*LANES-1:0] op_a, op_b;
   logic                op_s, op_v;
   logic [31:0]         tree_d [0:LOG2][0:LANES-1];
   logic [LOG2:0]       tree_s;
   logic [LOG2:0]       tree_v;
   logic [31:0]         beat_sum;

   // a zero-exponent operand makes the lane product +0
   always_comb begin
      a_masked = in_A;
      for (int i = 0; i < LANES; i++)
         if (!in_lane_mask[i]) a_masked[32*i +: 32] = 32'h0;
   end

   always_ff @(posedge aclk) begin
      if (beat_acc) begin
         op_a <= a_masked;
         op_b <= in_B;
         op_s <= in_acc_sign;
      end
      for (int i = 0; i < LANES; i++)
         tree_d[0][i] <= fp_mul(op_a[32*i +: 32], op_b[32*i +: 32]);
      tree_s[0] <= op_s;
      for (int k = 1; k <= LOG2; k++) begin
         tree_s[k] <= tree_s[k-1];
         for (int i = 0; i < LANES / 2; i++)
            if (i < (LANES >> k))
               tree_d[k][i] <= fp_add(tree_d[k-1][2*i], tree_d[k-1][2*i+1]);
      end
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         op_v   <= 1'b0;
         tree_v <= '0;
      end else begin
         op_v      <= beat_acc;
         tree_v[0] <= op_v;
         for (int k = 1; k <= LOG2; k++)
            tree_v[k] <= tree_v[k-1];
      end
   end

   // subtraction is an add with the beat-sum sign flipped
   assign beat_sum = {tree_s[LOG2] ? tree_d[LOG2][0][31] : ~tree_d[LOG2][0][31],
                      tree_d[LOG2][0][30:0]};

   always_ff @(posedge aclk or posedge areset) begin
      if (areset)
         acc <= 32'h0;
      else if (take)
         acc <= 32'h0;
      else if (state == BIAS)
         acc <= fp_add(acc, bias_q);
      else if (tree_v[LOG2])
         acc <= fp_add(acc, beat_sum);
   end

endmodule

// File: tb/tb_fp_dot_lanes_module.sv
// Directed bench for fp_dot_lanes_module (LANES=4, LEN_MAX=8).
// Inputs are driven 1 time unit after a rising edge; outputs are sampled there.
module tb_fp_dot_lanes_module;

   localparam int LANES   = 4;
   localparam int LEN_MAX = 8;

   localparam logic [31:0]  F1   = 32'h3F800000;
   localparam logic [127:0] ONE4 = {4{F1}};
   localparam logic [127:0] A1   = {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};
   localparam logic [127:0] B2   = {4{32'h40000000}};

   logic                 aclk = 1'b0;
   logic                 areset = 1'b0;
   logic [32*LANES-1:0]  in_A = '0;
   logic [32*LANES-1:0]  in_B = '0;
   logic [LANES-1:0]     in_lane_mask = '0;
   logic                 in_acc_sign = 1'b1;
   logic                 in_valid = 1'b0;
   logic                 in_last = 1'b0;
   logic                 in_ready;
   logic [31:0]          custom_last = 32'h0;
   logic                 en_custom_last = 1'b0;
   logic [31:0]          result_all;
   logic                 sendable;
   logic                 result_ready = 1'b0;
   logic [7:0]           beat_count;

   int n_run  = 0;
   int n_fail = 0;

   fp_dot_lanes_module #(.LANES(LANES), .LEN_MAX(LEN_MAX)) dut (
      .aclk           (aclk),
      .areset         (areset),
      .in_A           (in_A),
      .in_B           (in_B),
      .in_lane_mask   (in_lane_mask),
      .in_acc_sign    (in_acc_sign),
      .in_valid       (in_valid),
      .in_last        (in_last),
      .in_ready       (in_ready),
      .custom_last    (custom_last),
      .en_custom_last (en_custom_last),
      .result_all     (result_all),
      .sendable       (sendable),
      .result_ready   (result_ready),
      .beat_count     (beat_count)
   );

   always #5 aclk = ~aclk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step;
      @(posedge aclk);
      #1;
   endtask

   task automatic beat(input logic [127:0] a, input logic [127:0] b, input logic [3:0] m,
                       input logic s, input logic l);
      in_A = a; in_B = b; in_lane_mask = m; in_acc_sign = s; in_last = l; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic close_only;
      in_last = 1'b1;
      step();
      in_last = 1'b0;
   endtask

   // cycles counted from the close edge until sendable, bounded
   task automatic wait_send(output int n);
      n = 0;
      while (!sendable && n < 40) begin
         step();
         n++;
      end
      check_val("sendable_up", {31'b0, sendable}, 32'd1);
   endtask

   task automatic handshake;
      result_ready = 1'b1;
      step();
      result_ready = 1'b0;
      check_val("ready_after_take", {31'b0, in_ready}, 32'd1);
      check_val("send_after_take", {31'b0, sendable}, 32'd0);
   endtask

   task automatic run_single(input string tag, input logic [127:0] a, input logic [127:0] b,
                             input logic [3:0] m, input logic s, input logic [31:0] exp);
      int n;
      beat(a, b, m, s, 1'b1);
      wait_send(n);
      check_val(tag, result_all, exp);
      handshake();
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic [31:0] held;

      // reset
      #2 areset = 1'b1;
      #1;
      check_val("rst_ready", {31'b0, in_ready}, 32'd0);
      check_val("rst_send", {31'b0, sendable}, 32'd0);
      check_val("rst_result", result_all, 32'h0);
      check_val("rst_count", {24'b0, beat_count}, 32'd0);
      repeat (3) step();
      check_val("rst_ready_held", {31'b0, in_ready}, 32'd0);
      areset = 1'b0;
      step();
      check_val("ready_after_rst", {31'b0, in_ready}, 32'd1);

      // one beat, latency from the accept edge
      beat(A1, B2, 4'hF, 1'b1, 1'b1);
      wait_send(n);
      check_val("s1_latency", n, 32'd5);
      check_val("s1_result", result_all, 32'h41A00000);
      handshake();

      // eight beats auto-close
      for (int i = 0; i < 8; i++) begin
         check_val("s2_ready_in", {31'b0, in_ready}, 32'd1);
         beat(ONE4, ONE4, 4'hF, 1'b1, 1'b0);
      end
      check_val("s2_ready_drop", {31'b0, in_ready}, 32'd0);
      check_val("s2_count", {24'b0, beat_count}, 32'd8);
      wait_send(n);
      check_val("s2_result", result_all, 32'h42000000);
      check_val("s2_count_done", {24'b0, beat_count}, 32'd8);
      handshake();
      check_val("s2_count_clr", {24'b0, beat_count}, 32'd0);

      // add, subtract, bias
      beat(A1, B2, 4'hF, 1'b1, 1'b0);
      en_custom_last = 1'b1;
      custom_last    = 32'h41200000;
      beat(ONE4, ONE4, 4'hF, 1'b0, 1'b1);
      en_custom_last = 1'b0;
      custom_last    = 32'h0;
      wait_send(n);
      check_val("s3_result", result_all, 32'h41D00000);
      handshake();

      // lane mask, then empty vector with bias
      run_single("s4_mask", A1, B2, 4'b0011, 1'b1, 32'h40C00000);
      en_custom_last = 1'b1;
      custom_last    = 32'h41200000;
      close_only();
      en_custom_last = 1'b0;
      custom_last    = 32'h0;
      wait_send(n);
      check_val("s4_empty_result", result_all, 32'h41200000);
      check_val("s4_empty_count", {24'b0, beat_count}, 32'd0);
      handshake();

      // back-pressure on the result
      beat(ONE4, ONE4, 4'hF, 1'b1, 1'b1);
      wait_send(n);
      held = result_all;
      check_val("s5_result", held, 32'h40800000);
      for (int i = 0; i < 10; i++) begin
         step();
         check_val("s5_hold_send", {31'b0, sendable}, 32'd1);
         check_val("s5_hold_result", result_all, 32'h40800000);
         check_val("s5_hold_ready", {31'b0, in_ready}, 32'd0);
      end
      handshake();
      run_single("s5_next", ONE4, ONE4, 4'hF, 1'b1, 32'h40800000);

      // reset during DRAIN
      beat(A1, B2, 4'hF, 1'b1, 1'b1);
      step();
      areset = 1'b1;
      #1;
      check_val("s6_send_rst", {31'b0, sendable}, 32'd0);
      check_val("s6_ready_rst", {31'b0, in_ready}, 32'd0);
      step();
      areset = 1'b0;
      step();
      check_val("s6_ready_rel", {31'b0, in_ready}, 32'd1);
      check_val("s6_result_clr", result_all, 32'h0);
      check_val("s6_count_clr", {24'b0, beat_count}, 32'd0);
      run_single("s6_clean", ONE4, ONE4, 4'hF, 1'b1, 32'h40800000);

      // arithmetic corners
      run_single("rtz_mul", {96'h0, 32'h3FC00000}, {96'h0, 32'h3F800001}, 4'b0001, 1'b1, 32'h3FC00001);
      run_single("overflow", {96'h0, 32'h7F000000}, {96'h0, 32'h40000000}, 4'b0001, 1'b1, 32'h7F800000);
      run_single("denorm_in", {96'h0, 32'h00400000}, {96'h0, 32'h40000000}, 4'b0001, 1'b1, 32'h00000000);
      run_single("negate", A1, B2, 4'hF, 1'b0, 32'hC1A00000);

      en_custom_last = 1'b1;
      custom_last    = 32'h33C00000;
      run_single("rtz_add", {96'h0, F1}, {96'h0, F1}, 4'b0001, 1'b1, 32'h3F800000);
      en_custom_last = 1'b0;
      custom_last    = 32'h0;

      beat({96'h0, F1}, {96'h0, F1}, 4'b0001, 1'b1, 1'b0);
      beat({96'h0, F1}, {96'h0, F1}, 4'b0001, 1'b0, 1'b1);
      wait_send(n);
      check_val("zero_cancel", result_all, 32'h00000000);
      handshake();

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
